// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over req/ack, picks the next PC.
// 2+ cycles/instr; memory wait and stall each add a cycle; misaligned targets and fetch timeouts halt until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcSrc,
    input  logic [31:0] ImmExt,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        commit,
    output logic        misaligned,
    output logic        fetch_timeout
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc_q, pc_nxt;
    logic [31:0]      instr_q, instr_nxt;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt;
    logic             mis_q, mis_nxt;
    logic             to_q, to_nxt;
    logic [31:0]      next_pc;

    // Outputs decode only from registered state so imem_req never depends on imem_ack.
    assign imem_req      = (state == S_FETCH);
    assign instr_valid   = (state == S_EXEC);
    assign commit        = instr_valid & ~stall;
    assign imem_addr     = pc_q;
    assign PC            = pc_q;
    assign PCPlus4       = pc_q + 32'd4;
    assign Instr         = instr_q;
    assign misaligned    = mis_q;
    assign fetch_timeout = to_q;
    assign next_pc       = PcSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            wait_cnt <= '0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            wait_cnt <= cnt_nxt;
            mis_q    <= mis_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        cnt_nxt   = wait_cnt;
        mis_nxt   = mis_q;
        to_nxt    = to_q;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    cnt_nxt   = '0;
                    state_nxt = S_EXEC;
                end else begin
                    if (wait_cnt != CNT_SAT) cnt_nxt = wait_cnt + CNT_W'(1);
                    // This is the MAX_WAIT-th unacknowledged request cycle.
                    if (wait_cnt >= CNT_LAST) begin
                        to_nxt    = 1'b1;
                        state_nxt = S_HALT;
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        mis_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model of the PC/instruction flow with randomized memory delay and stalls.
module tb_instr_fetch_unit;
    logic        clk;
    logic        rst, pc_src, stall, imem_ack;
    logic [31:0] imm_ext, imem_rdata;
    logic        imem_req, instr_valid, commit, misaligned, fetch_timeout;
    logic [31:0] imem_addr, instr, pc, pc_plus4;

    logic        rst2, pc_src2, stall2, imem_ack2;
    logic [31:0] imm_ext2, imem_rdata2;
    logic        imem_req2, instr_valid2, commit2, misaligned2, fetch_timeout2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus4_2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc;
    logic [31:0] mem [logic [31:0]];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .PcSrc(pc_src), .ImmExt(imm_ext), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Instr(instr), .PC(pc), .PCPlus4(pc_plus4), .instr_valid(instr_valid), .commit(commit),
        .misaligned(misaligned), .fetch_timeout(fetch_timeout)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(255)) dut_wrap (
        .clk(clk), .rst(rst2), .PcSrc(pc_src2), .ImmExt(imm_ext2), .stall(stall2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .Instr(instr2), .PC(pc2), .PCPlus4(pc_plus4_2), .instr_valid(instr_valid2), .commit(commit2),
        .misaligned(misaligned2), .fetch_timeout(fetch_timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // One instruction: `delay` unacked request cycles, then `nstall` stalled EXEC cycles, then retire.
    task automatic do_instr(input int delay, input int nstall, input bit src, input logic [31:0] imm);
        logic [31:0] word, nxt;
        word = mem_word(exp_pc);
        for (int i = 0; i <= delay; i++) begin
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? word : $urandom;
            pc_src     = 1'($urandom);
            imm_ext    = $urandom;
            stall      = 1'($urandom);
            #1;
            n_cmp++;
            if ({imem_req, instr_valid, commit, misaligned, fetch_timeout} !== 5'b10000
                || imem_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
                n_bad++;
                $display("FAIL fetch_cycle%0d: req/vld/cmt/mis/to=%b addr=%h pc4=%h, expected 10000 addr=%h pc4=%h",
                         i, {imem_req, instr_valid, commit, misaligned, fetch_timeout}, imem_addr, pc_plus4,
                         exp_pc, exp_pc + 32'd4);
            end
            cycle();
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        for (int j = 0; j <= nstall; j++) begin
            stall   = (j < nstall);
            pc_src  = stall ? 1'($urandom) : src;
            imm_ext = stall ? $urandom : imm;
            #1;
            n_cmp++;
            if ({imem_req, instr_valid, commit} !== {2'b01, ~stall} || instr !== word || pc !== exp_pc) begin
                n_bad++;
                $display("FAIL exec_cycle%0d: req/vld/cmt=%b instr=%h pc=%h, expected %b instr=%h pc=%h",
                         j, {imem_req, instr_valid, commit}, instr, pc, {2'b01, ~stall}, word, exp_pc);
            end
            cycle();
        end
        nxt = src ? exp_pc + imm : exp_pc + 32'd4;
        if (nxt[1:0] != 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                imem_ack   = 1'($urandom);
                imem_rdata = $urandom;
                stall      = 1'($urandom);
                #1;
                n_cmp++;
                if ({imem_req, instr_valid, commit, misaligned} !== 4'b0001 || pc !== exp_pc || instr !== word) begin
                    n_bad++;
                    $display("FAIL halt_misaligned%0d: req/vld/cmt/mis=%b pc=%h instr=%h, expected 0001 pc=%h instr=%h",
                             k, {imem_req, instr_valid, commit, misaligned}, pc, instr, exp_pc, word);
                end
                cycle();
            end
        end else begin
            exp_pc = nxt;
        end
    endtask

    // Reset with an optional simultaneous ack, which must be discarded.
    task automatic test_reset(input bit with_ack);
        rst        = 1'b1;
        imem_ack   = with_ack;
        imem_rdata = $urandom;
        stall      = 1'b0;
        pc_src     = 1'($urandom);
        imm_ext    = $urandom;
        cycle();
        rst      = 1'b0;
        imem_ack = 1'b0;
        exp_pc   = 32'h0;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || instr !== 32'h13 || {imem_req, instr_valid, commit, misaligned, fetch_timeout} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset(ack=%0d): pc=%h instr=%h req/vld/cmt/mis/to=%b, expected pc=0 instr=13 10000",
                     with_ack, pc, instr, {imem_req, instr_valid, commit, misaligned, fetch_timeout});
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_branch();
        do_instr(0, 0, 1'b1, 32'hFFFF_FFF8);
        n_cmp++;
        if (exp_pc !== 32'h8) begin
            n_bad++;
            $display("FAIL branch_target: model pc=%h, expected 00000008 after branch from 10", exp_pc);
        end
        do_instr(0, 0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'hC) begin
            n_bad++;
            $display("FAIL branch_then_seq: addr=%h, expected 0000000c", imem_addr);
        end
        test_reset(1'b0);
        for (int i = 0; i < 2; i++) do_instr(0, 0, 1'b0, 32'h0);
        do_instr(0, 0, 1'b1, 32'h0000_0006);
    endtask

    task automatic test_slow_stall();
        do_instr(3, 2, 1'b0, 32'h0);
        do_instr(2, 1, 1'b1, 32'h0000_0010);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 63);
            do_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), 32'((k - 32) * 4));
        end
    endtask

    task automatic test_midop_reset();
        do_instr(1, 0, 1'b0, 32'h0);
        test_reset(1'b1);
        do_instr(0, 0, 1'b1, 32'h0000_0040);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        cycle();
        imem_ack = 1'b0;
        stall    = 1'b0;
        pc_src   = 1'b1;
        imm_ext  = 32'h100;
        #1;
        n_cmp++;
        if (commit !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_commit: commit=%b, expected 1", commit);
        end
        test_reset(1'b0);
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 4; c++) begin
            imem_ack = 1'b0;
            stall    = 1'($urandom);
            #1;
            n_cmp++;
            if (imem_req !== 1'b1 || fetch_timeout !== 1'b0 || imem_addr !== exp_pc) begin
                n_bad++;
                $display("FAIL timeout_wait%0d: req=%b to=%b addr=%h, expected req=1 to=0 addr=%h",
                         c, imem_req, fetch_timeout, imem_addr, exp_pc);
            end
            cycle();
        end
        for (int c = 0; c < 3; c++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            #1;
            n_cmp++;
            if ({imem_req, instr_valid, fetch_timeout} !== 3'b001 || pc !== exp_pc || instr !== 32'h13) begin
                n_bad++;
                $display("FAIL timeout_halt%0d: req/vld/to=%b pc=%h instr=%h, expected 001 pc=%h instr=13",
                         c, {imem_req, instr_valid, fetch_timeout}, pc, instr, exp_pc);
            end
            cycle();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] word;
        word        = $urandom;
        rst2        = 1'b1;
        imem_ack2   = 1'b0;
        stall2      = 1'b0;
        pc_src2     = 1'b0;
        imm_ext2    = 32'h0;
        imem_rdata2 = 32'h0;
        cycle();
        rst2        = 1'b0;
        imem_ack2   = 1'b1;
        imem_rdata2 = word;
        #1;
        n_cmp++;
        if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC || pc_plus4_2 !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_fetch: req=%b addr=%h pc4=%h, expected req=1 addr=fffffffc pc4=0",
                     imem_req2, imem_addr2, pc_plus4_2);
        end
        cycle();
        imem_ack2 = 1'b0;
        #1;
        n_cmp++;
        if ({instr_valid2, commit2} !== 2'b11 || instr2 !== word) begin
            n_bad++;
            $display("FAIL wrap_exec: vld/cmt=%b instr=%h, expected 11 instr=%h", {instr_valid2, commit2}, instr2, word);
        end
        cycle();
        #1;
        n_cmp++;
        if (pc2 !== 32'h0 || imem_addr2 !== 32'h0 || {imem_req2, misaligned2, fetch_timeout2} !== 3'b100) begin
            n_bad++;
            $display("FAIL wrap_next: pc=%h addr=%h req/mis/to=%b, expected pc=0 addr=0 100",
                     pc2, imem_addr2, {imem_req2, misaligned2, fetch_timeout2});
        end
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; stall = 1'b0; imem_ack = 1'b0; imm_ext = 32'h0; imem_rdata = 32'h0;
        rst2 = 1'b1; pc_src2 = 1'b0; stall2 = 1'b0; imem_ack2 = 1'b0; imm_ext2 = 32'h0; imem_rdata2 = 32'h0;
        exp_pc = 32'h0;
        cycle();
        test_reset(1'b0);
        test_sequential();
        test_branch();
        test_reset(1'b0);
        test_slow_stall();
        test_random();
        test_midop_reset();
        test_timeout();
        test_reset(1'b0);
        do_instr(1, 1, 1'b0, 32'h0);
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
